// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the native memory-bus slave.
// Provides bus widths and the controller state encoding.
package mem_bus_pkg;

  localparam int WORD_BYTES = 4;
  localparam int XLEN       = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bram_state_t;

endpackage

// File: rtl/bram_sp.sv
// Single-port byte-write RAM with registered read, BRAM-inferable.
// Ports: clk, en, we[3:0] (0 = read), addr, wdata, rdata.
module bram_sp
  import mem_bus_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int AW        = 12,
  parameter     INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [AW-1:0]         addr,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Read register only updates on reads so
  // the last read word stays on rdata.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      if (we == '0) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bram_controller.sv
// Block-RAM slave on the valid/ready native memory bus.
// Ports: clk, reset_n, mem_valid/ready, mem_addr, mem_wdata, mem_wstrb, mem_rdata.
module bram_controller
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter     INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [XLEN-1:0]       mem_addr,
  input  logic [XLEN-1:0]       mem_wdata,
  input  logic [WORD_BYTES-1:0] mem_wstrb,
  output logic [XLEN-1:0]       mem_rdata
);

  localparam int ADDR_BITS = $clog2(DEPTH_WORDS);

  bram_state_t state_q;
  bram_state_t state_d;

  logic                  accept;
  logic                  is_read;
  logic                  have_data;
  logic [ADDR_BITS-1:0]  idx;
  logic [WORD_BYTES-1:0] we;
  logic [XLEN-1:0]       ram_rdata;

  // Byte offset and bits above the RAM size are
  // dropped, so the memory aliases.
  assign idx     = mem_addr[ADDR_BITS+1:2];
  assign is_read = (mem_wstrb == '0);
  assign accept  = (state_q == IDLE) && mem_valid;
  assign we      = accept ? mem_wstrb : '0;

  logic unused_addr;
  assign unused_addr = ^{mem_addr[XLEN-1:ADDR_BITS+2],
                         mem_addr[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mem_valid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gates the RAM output register so rdata is 0
  // after reset until the first read lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_data <= 1'b0;
    end else if (accept && is_read) begin
      have_data <= 1'b1;
    end
  end

  assign mem_ready = (state_q == RESP);
  assign mem_rdata = have_data ? ram_rdata : '0;

  bram_sp #(
    .DEPTH     (DEPTH_WORDS),
    .AW        (ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (accept),
    .we    (we),
    .addr  (idx),
    .wdata (mem_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_bram_controller.sv
// Directed self-checking bench for bram_controller.
// Drives bus transactions and checks ready timing and data.
module tb_bram_controller;

  localparam int DEPTH = 4096;

  logic        clk;
  logic        reset_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_fails;

  bram_controller #(
    .DEPTH_WORDS (DEPTH),
    .INIT_FILE   ("")
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // One bus access; checks one-cycle latency and
  // a single-cycle ready pulse.
  task automatic access(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0]  s,
                        output logic [31:0] rd);
    int n;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mem_ready && n < 8);
    check({tag, "_ready"}, {31'd0, mem_ready}, 32'd1);
    check({tag, "_lat"}, n, 32'd1);
    rd = mem_rdata;
    mem_valid = 1'b0;
    mem_addr  = 32'hFFFF_FFFC;
    mem_wdata = 32'hDEAD_BEEF;
    mem_wstrb = 4'hF;
    @(posedge clk);
    #1;
    check({tag, "_drop"}, {31'd0, mem_ready}, 32'd0);
  endtask

  logic [31:0] rd;

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset_n   = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", {31'd0, mem_ready}, 32'd0);

    // Basic write then read
    access("w0", 32'h0, 32'h0000_1111, 4'hF, rd);
    check("w0_rdata_untouched", rd, 32'd0);
    access("r0", 32'h0, 32'h0, 4'h0, rd);
    check("r0_data", rd, 32'h0000_1111);

    // Byte merge
    access("w8", 32'h8, 32'hAABB_CCDD, 4'hF, rd);
    access("w8b", 32'h8, 32'h0000_0011, 4'b0001, rd);
    access("r8", 32'h8, 32'h0, 4'h0, rd);
    check("r8_merge", rd, 32'hAABB_CC11);

    // Alignment and aliasing
    access("r0b", 32'h0, 32'h0, 4'h0, rd);
    check("r0b_data", rd, 32'h0000_1111);
    access("rB", 32'hB, 32'h0, 4'h0, rd);
    check("rB_align", rd, 32'hAABB_CC11);
    access("r0c", 32'h0, 32'h0, 4'h0, rd);
    access("ralias", 32'h8 + 4 * DEPTH, 32'h0, 4'h0, rd);
    check("ralias_data", rd, 32'hAABB_CC11);

    // Write after read leaves rdata alone
    access("r0d", 32'h0, 32'h0, 4'h0, rd);
    check("r0d_data", rd, 32'h0000_1111);
    access("w10", 32'h10, 32'h5555_5555, 4'hF, rd);
    check("w10_hold", rd, 32'h0000_1111);
    access("w10b", 32'h10, 32'h1234_5678, 4'b1100, rd);
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold", mem_rdata, 32'h0000_1111);
    access("r10", 32'h10, 32'h0, 4'h0, rd);
    check("r10_merge", rd, 32'h1234_5555);

    // Valid held past ready: two spaced accesses
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h0;
    mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    check("hold_rdy1", {31'd0, mem_ready}, 32'd1);
    check("hold_data1", mem_rdata, 32'h0000_1111);
    mem_addr = 32'h8;
    @(posedge clk);
    #1;
    check("hold_gap", {31'd0, mem_ready}, 32'd0);
    check("hold_gap_data", mem_rdata, 32'h0000_1111);
    @(posedge clk);
    #1;
    check("hold_rdy2", {31'd0, mem_ready}, 32'd1);
    check("hold_data2", mem_rdata, 32'hAABB_CC11);
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hold_end", {31'd0, mem_ready}, 32'd0);

    // Reset while in RESP after a committed write
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h20;
    mem_wdata = 32'hCAFE_F00D;
    mem_wstrb = 4'hF;
    @(posedge clk);
    #1;
    check("rr_ready", {31'd0, mem_ready}, 32'd1);
    #1;
    reset_n   = 1'b0;
    mem_valid = 1'b0;
    #1;
    check("rr_cancel", {31'd0, mem_ready}, 32'd0);
    check("rr_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    access("r20", 32'h20, 32'h0, 4'h0, rd);
    check("r20_kept", rd, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
